// File: rtl/opb_register_ppc2fabric.sv
// -----------------------------------------------------------------------------
// opb_register_ppc2fabric
//   OPB slave holding a 32-bit control word written by the PowerPC and
//   presented to fabric logic on user_data_out, with a one-cycle
//   user_data_valid pulse on every byte-enabled write of DATA.
//
//   Register map (word offset = OPB_ABus[28:29]):
//     0x0 DATA   read/write, byte-enabled writes
//     0x4 WCOUNT read-only count of committed DATA writes (wraps)
//     other in-window offsets: acknowledged, read 0, writes ignored
//
//   Build option: define OPB_PPC2FABRIC_READBACK_EN to enable read-back of
//   DATA and WCOUNT. Without it every read returns 0 (still acknowledged)
//   and the WCOUNT counter is not built.
//
//   Transfer timing: a hit is captured at edge N while IDLE, the ACK state
//   is entered at edge N+1 (write commit, read data registered), and the
//   acknowledge drops at edge N+2. OPB_select is ignored while in ACK.
// -----------------------------------------------------------------------------
module opb_register_ppc2fabric #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst_n,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic [31:0] user_data_out,
   output logic        user_data_valid
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_e;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_WCOUNT = 2'd1;

   state_e      state_q, state_d;
   logic        req_pend_q, req_pend_d;    // captured hit waiting for ACK
   logic        req_rnw_q, req_rnw_d;
   logic [1:0]  req_off_q, req_off_d;
   logic [3:0]  req_be_q, req_be_d;        // bit 3 qualifies data bits 31:24
   logic [31:0] req_data_q, req_data_d;
   logic [31:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merged_data;
   logic [31:0] read_word;
   logic        hit;

   // Hit test as an offset compare so a zero base address needs no
   // always-true comparison.
   assign hit = OPB_select &&
                ((OPB_ABus - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR));

   // Byte merge of the captured write into DATA; OPB bit i lands on bit 31-i,
   // which the plain vector copies of OPB_DBus/OPB_BE already give.
   always_comb begin
      merged_data = data_q;
      for (int j = 0; j < 4; j++) begin
         if (req_be_q[j]) merged_data[8*j +: 8] = req_data_q[8*j +: 8];
      end
   end

`ifdef OPB_PPC2FABRIC_READBACK_EN
   logic [31:0] wcount_q, wcount_d;

   // Read mux over the pre-commit register values.
   always_comb begin
      case (req_off_q)
         OFF_DATA:   read_word = data_q;
         OFF_WCOUNT: read_word = wcount_q;
         default:    read_word = 32'h0;
      endcase
   end

   // Committed-write counter, wrapping naturally at 32 bits.
   always_comb begin
      wcount_d = wcount_q;
      if (state_q == IDLE && req_pend_q && !req_rnw_q &&
          req_off_q == OFF_DATA && req_be_q != 4'b0000) begin
         wcount_d = wcount_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) wcount_q <= 32'h0;
      else            wcount_q <= wcount_d;
   end
`else
   // Read-back disabled: reads are acknowledged but always return zero.
   assign read_word = 32'h0;
`endif

   // Next-state and transfer decode for the IDLE/ACK handshake.
   // NOTE: every signal gets a default first so no path leaves a latch.
   always_comb begin
      state_d    = state_q;
      req_pend_d = req_pend_q;
      req_rnw_d  = req_rnw_q;
      req_off_d  = req_off_q;
      req_be_d   = req_be_q;
      req_data_d = req_data_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      rdata_d    = 32'h0;
      case (state_q)
         IDLE: begin
            if (!req_pend_q) begin
               req_pend_d = hit;
               req_rnw_d  = OPB_RNW;
               req_off_d  = OPB_ABus[28:29];
               req_be_d   = OPB_BE;
               req_data_d = OPB_DBus;
            end else begin
               req_pend_d = 1'b0;
               state_d    = ACK;
               if (req_rnw_q) begin
                  rdata_d = read_word;
               end else if (req_off_q == OFF_DATA && req_be_q != 4'b0000) begin
                  data_d  = merged_data;
                  valid_d = 1'b1;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, request capture and output registers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q    <= IDLE;
         req_pend_q <= 1'b0;
         req_rnw_q  <= 1'b0;
         req_off_q  <= 2'd0;
         req_be_q   <= 4'b0000;
         req_data_q <= 32'h0;
         data_q     <= C_INIT_VALUE;
         valid_q    <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         req_pend_q <= req_pend_d;
         req_rnw_q  <= req_rnw_d;
         req_off_q  <= req_off_d;
         req_be_q   <= req_be_d;
         req_data_q <= req_data_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign Sl_xferAck      = (state_q == ACK);
   assign Sl_DBus         = rdata_q;
   assign Sl_errAck       = 1'b0;
   assign Sl_retry        = 1'b0;
   assign Sl_toutSup      = 1'b0;
   assign user_data_out   = data_q;
   assign user_data_valid = valid_q;

   // Sequential-address hint and bus-width parameters carry no behaviour here.
   logic unused_inputs;
   assign unused_inputs = OPB_seqAddr ^ (C_OPB_AWIDTH != 32) ^ (C_OPB_DWIDTH != 32);

endmodule
